overlay_screen: RTL

//  Parametrised full-screen generator for start/finish/pause screens on the VGA

---
 rtl/overlay_screen.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/overlay_screen.sv
// overlay_screen: full-screen start/finish/pause overlay for the VGA chain.
// Two-stage pipeline (region decode, then colour select + fade), with a
// frame-synchronous FSM that handles mode switching, fade-in and banner blink.
// The vga_if bundle is carried as flattened vga_in_*/vga_out_* ports.
module overlay_screen #(
  parameter int          BOX_X0       = 160,
  parameter int          BOX_X1       = 650,
  parameter int          BOX_Y0       = 250,
  parameter int          BOX_Y1       = 320,
  parameter logic [11:0] BG_START     = 12'h00f,
  parameter logic [11:0] BG_FINISH    = 12'h0f0,
  parameter logic [11:0] BG_PAUSE     = 12'h444,
  parameter logic [11:0] BOX_RGB      = 12'hff0,
  parameter int          FADE_FRAMES  = 4,
  parameter int          BLINK_FRAMES = 30,
  parameter int          HOR_PIXELS   = 800,
  parameter int          VER_PIXELS   = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  output logic        busy,
  input  logic [10:0] vga_in_vcount,
  input  logic        vga_in_vsync,
  input  logic        vga_in_vblnk,
  input  logic [10:0] vga_in_hcount,
  input  logic        vga_in_hsync,
  input  logic        vga_in_hblnk,
  input  logic [11:0] vga_in_rgb,
  output logic [10:0] vga_out_vcount,
  output logic        vga_out_vsync,
  output logic        vga_out_vblnk,
  output logic [10:0] vga_out_hcount,
  output logic        vga_out_hsync,
  output logic        vga_out_hblnk,
  output logic [11:0] vga_out_rgb
);

  localparam logic [10:0] X0      = 11'(BOX_X0);
  localparam logic [10:0] X1      = 11'(BOX_X1);
  localparam logic [10:0] Y0      = 11'(BOX_Y0);
  localparam logic [10:0] Y1      = 11'(BOX_Y1);
  localparam logic [10:0] H_LAST  = 11'(HOR_PIXELS - 1);
  localparam logic [10:0] V_LAST  = 11'(VER_PIXELS - 1);
  localparam bit          FADE_EN  = (FADE_FRAMES > 0);
  localparam bit          BLINK_EN = (BLINK_FRAMES > 0);
  localparam logic [15:0] FADE_LAST  = 16'((FADE_FRAMES > 0) ? FADE_FRAMES - 1 : 0);
  localparam logic [15:0] BLINK_LAST = 16'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

  typedef enum logic [1:0] {OFF = 2'd0, FADE = 2'd1, SHOW = 2'd2} state_t;

  state_t      state_reg;
  logic [1:0]  cur_mode_reg;
  logic [3:0]  fade_lvl_reg;
  logic [15:0] fade_cnt_reg;
  logic [15:0] blink_cnt_reg;
  logic        blink_on_reg;
  logic        run_reg;

  logic [10:0] hcount_s1_reg, vcount_s1_reg;
  logic        hsync_s1_reg, vsync_s1_reg, hblnk_s1_reg, vblnk_s1_reg;
  logic [11:0] rgb_s1_reg;
  logic        top_s1_reg, bottom_s1_reg, left_s1_reg, right_s1_reg, box_s1_reg;
  logic        vblnk_prev_reg;
  logic        frame_tick;

  logic [11:0] color_next;
  logic [11:0] rgb_next;

  // Per-channel fade: (c * (lvl + 1)) >> 4, so lvl 15 is identity.
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] lvl);
    logic [7:0] prod;
    prod = {4'd0, c} * ({4'd0, lvl} + 8'd1);
    return 4'(prod >> 4);
  endfunction

  assign frame_tick = vblnk_s1_reg & ~vblnk_prev_reg;

  // Stage 1: register the incoming bundle and decode screen regions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_s1_reg  <= '0;
      vcount_s1_reg  <= '0;
      hsync_s1_reg   <= 1'b0;
      vsync_s1_reg   <= 1'b0;
      hblnk_s1_reg   <= 1'b0;
      vblnk_s1_reg   <= 1'b0;
      rgb_s1_reg     <= '0;
      top_s1_reg     <= 1'b0;
      bottom_s1_reg  <= 1'b0;
      left_s1_reg    <= 1'b0;
      right_s1_reg   <= 1'b0;
      box_s1_reg     <= 1'b0;
      vblnk_prev_reg <= 1'b0;
    end else begin
      hcount_s1_reg  <= vga_in_hcount;
      vcount_s1_reg  <= vga_in_vcount;
      hsync_s1_reg   <= vga_in_hsync;
      vsync_s1_reg   <= vga_in_vsync;
      hblnk_s1_reg   <= vga_in_hblnk;
      vblnk_s1_reg   <= vga_in_vblnk;
      rgb_s1_reg     <= vga_in_rgb;
      top_s1_reg     <= (vga_in_vcount == 11'd0);
      bottom_s1_reg  <= (vga_in_vcount == V_LAST);
      left_s1_reg    <= (vga_in_hcount == 11'd0);
      right_s1_reg   <= (vga_in_hcount == H_LAST);
      box_s1_reg     <= (vga_in_hcount > X0) && (vga_in_hcount < X1) &&
                        (vga_in_vcount > Y0) && (vga_in_vcount < Y1);
      vblnk_prev_reg <= vblnk_s1_reg;
    end
  end

  // Frame-synchronous FSM: mode is only sampled on frame_tick so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= OFF;
      cur_mode_reg  <= 2'd0;
      fade_lvl_reg  <= 4'd0;
      fade_cnt_reg  <= '0;
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
      busy          <= 1'b0;
      run_reg       <= 1'b0;
    end else if (frame_tick) begin
      run_reg <= 1'b1;
      if (mode == 2'd0) begin
        state_reg    <= OFF;
        cur_mode_reg <= 2'd0;
        busy         <= 1'b0;
      end else if (state_reg == OFF || mode != cur_mode_reg) begin
        // (Re)start the fade for the newly requested screen.
        state_reg     <= FADE;
        cur_mode_reg  <= mode;
        fade_lvl_reg  <= 4'd0;
        fade_cnt_reg  <= '0;
        blink_cnt_reg <= '0;
        blink_on_reg  <= 1'b1;
        busy          <= 1'b1;
      end else begin
        if (!BLINK_EN) begin
          blink_on_reg <= 1'b1;
        end else if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_reg <= '0;
          blink_on_reg  <= ~blink_on_reg;
        end else begin
          blink_cnt_reg <= blink_cnt_reg + 16'd1;
        end
        if (state_reg == FADE) begin
          if (!FADE_EN) begin
            fade_lvl_reg <= 4'd15;
            state_reg    <= SHOW;
            busy         <= 1'b0;
          end else if (fade_cnt_reg == FADE_LAST) begin
            fade_cnt_reg <= '0;
            fade_lvl_reg <= fade_lvl_reg + 4'd1;
            if (fade_lvl_reg == 4'd14) begin
              state_reg <= SHOW;
              busy      <= 1'b0;
            end
          end else begin
            fade_cnt_reg <= fade_cnt_reg + 16'd1;
          end
        end
      end
    end
  end

  // Colour select by priority, then fade; OFF passes through, blanking and pre-sync are black.
  always_comb begin
    color_next = 12'h000;
    case (cur_mode_reg)
      2'd1:    color_next = BG_START;
      2'd2:    color_next = BG_FINISH;
      2'd3:    color_next = BG_PAUSE;
      default: color_next = 12'h000;
    endcase
    if (top_s1_reg)                        color_next = 12'hff0;
    else if (bottom_s1_reg)                color_next = 12'hf00;
    else if (left_s1_reg)                  color_next = 12'h0f0;
    else if (right_s1_reg)                 color_next = 12'h00f;
    else if (box_s1_reg && blink_on_reg)   color_next = BOX_RGB;
    rgb_next = {scale(color_next[11:8], fade_lvl_reg),
                scale(color_next[7:4],  fade_lvl_reg),
                scale(color_next[3:0],  fade_lvl_reg)};
    if (state_reg == OFF)
      rgb_next = rgb_s1_reg;
    if (vblnk_s1_reg || hblnk_s1_reg || !run_reg)
      rgb_next = 12'h000;
  end

  // Stage 2: final colour plus the timing fields, all delayed by two cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_out_vcount <= '0;
      vga_out_vsync  <= 1'b0;
      vga_out_vblnk  <= 1'b0;
      vga_out_hcount <= '0;
      vga_out_hsync  <= 1'b0;
      vga_out_hblnk  <= 1'b0;
      vga_out_rgb    <= '0;
    end else begin
      vga_out_vcount <= vcount_s1_reg;
      vga_out_vsync  <= vsync_s1_reg;
      vga_out_vblnk  <= vblnk_s1_reg;
      vga_out_hcount <= hcount_s1_reg;
      vga_out_hsync  <= hsync_s1_reg;
      vga_out_hblnk  <= hblnk_s1_reg;
      vga_out_rgb    <= rgb_next;
    end
  end

endmodule
